mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data RAM port between the instruction-fetch path and the load/store unit.
- Arbitrates round-robin and tracks one outstanding access with a fixed RAM read latency, then returns read data and a completion strobe to the owning requester.
- Sits between the core and the RAM. The LSU-side port carries the LSU's addr/width/w_rn/data signals unchanged.
- Detects misaligned LSU accesses and blocks them from reaching the RAM.

Parameters:
- RD_LATENCY, 1, cycles from the ram_en_o cycle to the cycle ram_rdata_i is valid. Legal range 1..7.
- XLEN / RAM_WIDTH: taken from imhotep_pkg, not overridable here.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request; held with if_addr_i until granted
- if_addr_i  in  RAM_WIDTH  fetch address; bits [1:0] ignored
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  XLEN  fetch read data
- ls_req_i  in  1  LSU request; held with all ls_* inputs until granted
- ls_addr_i  in  RAM_WIDTH  LSU address
- ls_w_rn_i  in  1  1 = write, 0 = read
- ls_width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- ls_wdata_i  in  XLEN  store data
- ls_gnt_o  out  1  LSU request accepted this cycle
- ls_rvalid_o  out  1  LSU access complete (read or write), one-cycle pulse
- ls_rdata_o  out  XLEN  LSU read data (raw RAM word; LSU extends it)
- ls_err_o  out  1  qualifies ls_rvalid_o: access was misaligned or illegal and was not performed
- ram_en_o  out  1  RAM access strobe
- ram_addr_o  out  RAM_WIDTH  RAM address
- ram_w_rn_o  out  1  RAM write enable
- ram_width_o  out  2  RAM access width
- ram_wdata_o  out  XLEN  RAM write data
- ram_rdata_i  in  XLEN  RAM read data

Behaviour:
- Reset values (registered state):
  - state = IDLE; lat_cnt = 0; owner = IF; last_gnt = IF (so the LSU wins the first tie).
  - No pending err.
  - All outputs 0 in the cycle after reset.
- Combinational outputs: gnt, ram_* and rvalid/rdata are all decoded from the state plus current inputs.
  - ram_* outputs are 0 whenever ram_en_o = 0.
  - if_rdata_o / ls_rdata_o = ram_rdata_i only while the matching rvalid is 1, else 0.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: waiting for RAM data. lat_cnt counts 1..RD_LATENCY.
  - ERR: one-cycle error response.
- Arbitration (a grant may be issued only in IDLE, or in BUSY during the completion cycle):
  - A single requester wins outright.
  - If both request, the port not equal to last_gnt wins.
  - The winner gets gnt = 1 for exactly that cycle; last_gnt and owner update to the winner.
- Fetch grant:
  - ram_en_o = 1, ram_addr_o = {if_addr_i[RAM_WIDTH-1:2], 2'b00}, ram_width_o = 10, ram_w_rn_o = 0.
  - Next state BUSY, lat_cnt = 1.
- LSU grant, aligned:
  - Aligned means: width 00; width 01 with addr[0] = 0; width 10 with addr[1:0] = 00.
  - ram_en_o = 1; ram_addr_o, ram_width_o, ram_w_rn_o, ram_wdata_o = the ls_* inputs.
  - Next state BUSY.
- LSU grant, misaligned or width 11:
  - ls_gnt_o = 1, ram_en_o = 0. Next state ERR.
  - In ERR: ls_rvalid_o = 1 and ls_err_o = 1 for one cycle, no new grant that cycle, then IDLE.
- BUSY:
  - lat_cnt increments each cycle.
  - Completion cycle is when lat_cnt == RD_LATENCY, i.e. grant cycle T + RD_LATENCY.
  - In that cycle the owner's rvalid = 1 with rdata passed through.
  - Writes also complete with ls_rvalid_o at T + RD_LATENCY; ls_rdata_o is 0 for writes.
- Back-to-back:
  - A new grant may be issued in the completion cycle (next state BUSY, lat_cnt = 1); otherwise the next state is IDLE.
  - RD_LATENCY = 1 therefore sustains one access per cycle.
- Only one transaction is ever outstanding. Requests arriving while BUSY and before the completion cycle see gnt = 0 and must hold.
- Reset mid-transaction: the in-flight access is dropped and no rvalid is issued for it.
- No fetch error path: fetch low address bits are forced to 00.

Test Plan:
- Single fetch, RD_LATENCY = 1:
  - Stimulus: if_req_i = 1, if_addr_i = 0x0013, RAM returns 0xDEADBEEF.
  - Required: if_gnt_o and ram_en_o in cycle T with ram_addr_o = 0x0010 and width 10; if_rvalid_o at T+1 with 0xDEADBEEF.
- Simultaneous requests out of reset, both held for 4 cycles:
  - Required grant order LSU, IF, LSU, IF; each rvalid goes to the correct port only.
- RD_LATENCY = 3, LSU load then store:
  - Required: ls_rvalid_o at T+3; next grant no earlier than T+3; store drives ram_w_rn_o = 1 and ram_wdata_o = 0x000000AA with width 00.
- LSU half-word at address 0x0005:
  - Required: ls_gnt_o = 1 with ram_en_o = 0; next cycle ls_rvalid_o = 1 and ls_err_o = 1; a pending fetch is granted the cycle after.
- LSU width 11 at address 0x0000:
  - Required: same error response as the misaligned case.
- Reset mid-transaction, RD_LATENCY = 3:
  - Stimulus: assert rst_i at T+1 after a fetch grant.
  - Required: no if_rvalid_o at T+3; all outputs 0; the first tie after reset goes to the LSU.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared width package and the arbiter's core/RAM-side bundle.
// The arbiter binds to the slave modport; whatever drives requests and RAM data takes the master modport.
package imhotep_pkg;
    localparam int XLEN      = 32;
    localparam int RAM_WIDTH = 16;
endpackage

interface mem_arbiter_if;
    // fetch port
    logic                            if_req_i;
    logic [imhotep_pkg::RAM_WIDTH-1:0] if_addr_i;
    logic                            if_gnt_o;
    logic                            if_rvalid_o;
    logic [imhotep_pkg::XLEN-1:0]    if_rdata_o;
    // load/store port
    logic                            ls_req_i;
    logic [imhotep_pkg::RAM_WIDTH-1:0] ls_addr_i;
    logic                            ls_w_rn_i;
    logic [1:0]                      ls_width_i;
    logic [imhotep_pkg::XLEN-1:0]    ls_wdata_i;
    logic                            ls_gnt_o;
    logic                            ls_rvalid_o;
    logic [imhotep_pkg::XLEN-1:0]    ls_rdata_o;
    logic                            ls_err_o;
    // RAM port
    logic                            ram_en_o;
    logic [imhotep_pkg::RAM_WIDTH-1:0] ram_addr_o;
    logic                            ram_w_rn_o;
    logic [1:0]                      ram_width_o;
    logic [imhotep_pkg::XLEN-1:0]    ram_wdata_o;
    logic [imhotep_pkg::XLEN-1:0]    ram_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_addr_i, ls_w_rn_i, ls_width_i, ls_wdata_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output ram_en_o, ram_addr_o, ram_w_rn_o, ram_width_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_addr_i, ls_w_rn_i, ls_width_i, ls_wdata_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  ram_en_o, ram_addr_o, ram_w_rn_o, ram_width_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin share of one RAM port between instruction fetch and the LSU, one access in flight.
// Latency: grant and RAM strobe same cycle, rvalid RD_LATENCY cycles later; misaligned LSU accesses answer with err one cycle later.
// Backpressure: gnt is held low while an access is outstanding; requesters hold their inputs until granted.
module mem_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);
    import imhotep_pkg::*;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state_q,    state_d;
    logic [2:0]  lat_cnt_q,  lat_cnt_d;
    port_t       owner_q,    owner_d;
    port_t       last_gnt_q, last_gnt_d;
    logic        wr_q,       wr_d;

    logic        done;
    logic        can_grant;
    logic        pick_ls;
    logic        ls_aligned;
    logic        if_gnt;
    logic        ls_gnt;
    logic        unused_if_lsb;

    assign unused_if_lsb = ^bus.if_addr_i[1:0];

    always_comb begin
        unique case (bus.ls_width_i)
            2'b00:   ls_aligned = 1'b1;
            2'b01:   ls_aligned = ~bus.ls_addr_i[0];
            2'b10:   ls_aligned = (bus.ls_addr_i[1:0] == 2'b00);
            default: ls_aligned = 1'b0;
        endcase
    end

    // A new grant is allowed when idle or in the cycle the current access completes;
    // on a tie the port that was not granted last time wins.
    assign done      = (state_q == ST_BUSY) && (lat_cnt_q == LAT);
    assign can_grant = !rst_i && ((state_q == ST_IDLE) || done);
    assign pick_ls   = bus.ls_req_i && (!bus.if_req_i || (last_gnt_q == PORT_IF));
    assign if_gnt    = can_grant && bus.if_req_i && !pick_ls;
    assign ls_gnt    = can_grant && pick_ls;

    always_comb begin
        bus.if_gnt_o    = if_gnt;
        bus.ls_gnt_o    = ls_gnt;
        bus.ram_en_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_w_rn_o  = 1'b0;
        bus.ram_width_o = 2'b00;
        bus.ram_wdata_o = '0;
        if (if_gnt) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = {bus.if_addr_i[RAM_WIDTH-1:2], 2'b00};
            bus.ram_width_o = 2'b10;
        end else if (ls_gnt && ls_aligned) begin
            bus.ram_en_o    = 1'b1;
            bus.ram_addr_o  = bus.ls_addr_i;
            bus.ram_w_rn_o  = bus.ls_w_rn_i;
            bus.ram_width_o = bus.ls_width_i;
            bus.ram_wdata_o = bus.ls_wdata_i;
        end
    end

    always_comb begin
        bus.if_rvalid_o = !rst_i && done && (owner_q == PORT_IF);
        bus.ls_rvalid_o = !rst_i && ((done && (owner_q == PORT_LS)) || (state_q == ST_ERR));
        bus.ls_err_o    = !rst_i && (state_q == ST_ERR);
        bus.if_rdata_o  = bus.if_rvalid_o ? bus.ram_rdata_i : '0;
        // Stores and rejected accesses return no data.
        bus.ls_rdata_o  = (bus.ls_rvalid_o && !bus.ls_err_o && !wr_q) ? bus.ram_rdata_i : '0;
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;

        unique case (state_q)
            ST_BUSY: begin
                if (done) begin
                    state_d   = ST_IDLE;
                    lat_cnt_d = 3'd0;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            ST_ERR: begin
                state_d   = ST_IDLE;
                lat_cnt_d = 3'd0;
            end
            default: ;
        endcase

        if (if_gnt) begin
            state_d    = ST_BUSY;
            lat_cnt_d  = 3'd1;
            owner_d    = PORT_IF;
            last_gnt_d = PORT_IF;
            wr_d       = 1'b0;
        end else if (ls_gnt) begin
            owner_d    = PORT_LS;
            last_gnt_d = PORT_LS;
            if (ls_aligned) begin
                state_d   = ST_BUSY;
                lat_cnt_d = 3'd1;
                wr_d      = bus.ls_w_rn_i;
            end else begin
                state_d   = ST_ERR;
                lat_cnt_d = 3'd0;
                wr_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= 3'd0;
            owner_q    <= PORT_IF;
            last_gnt_q <= PORT_IF;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at RD_LATENCY 1 and one at 3, each with a small RAM model.
// Expected responses are queued at grant time and matched by a per-instance monitor when rvalid appears.
module tb_mem_arbiter;
    import imhotep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus1();
    mem_arbiter_if bus3();

    mem_arbiter #(.RD_LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    mem_arbiter #(.RD_LATENCY(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));

    typedef struct {
        logic            is_ls;
        logic            err;
        logic [XLEN-1:0] rdata;
        int              due;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1, e3;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    localparam int OW = 3*XLEN + RAM_WIDTH + 9;
    wire [OW-1:0] outs1 = {bus1.if_gnt_o, bus1.if_rvalid_o, bus1.if_rdata_o, bus1.ls_gnt_o,
                           bus1.ls_rvalid_o, bus1.ls_rdata_o, bus1.ls_err_o, bus1.ram_en_o,
                           bus1.ram_addr_o, bus1.ram_w_rn_o, bus1.ram_width_o, bus1.ram_wdata_o};
    wire [OW-1:0] outs3 = {bus3.if_gnt_o, bus3.if_rvalid_o, bus3.if_rdata_o, bus3.ls_gnt_o,
                           bus3.ls_rvalid_o, bus3.ls_rdata_o, bus3.ls_err_o, bus3.ram_en_o,
                           bus3.ram_addr_o, bus3.ram_w_rn_o, bus3.ram_width_o, bus3.ram_wdata_o};

    // RAM models: read data appears RD_LATENCY cycles after the address cycle.
    logic [XLEN-1:0]      mem [16];
    logic [RAM_WIDTH-1:0] pipe1;
    logic [RAM_WIDTH-1:0] pipe3 [3];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        pipe1    <= bus1.ram_addr_o;
        pipe3[0] <= bus3.ram_addr_o;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus1.ram_rdata_i = mem[pipe1[5:2]];
    assign bus3.ram_rdata_i = mem[pipe3[2][5:2]];

    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus1.if_rvalid_o) begin
                n_cmp++;
                if (bus1.if_rdata_o !== '0) begin
                    n_bad++; $display("FAIL dut1_if_rdata_idle: got %h, required 0", bus1.if_rdata_o);
                end
            end
            if (!bus1.ls_rvalid_o) begin
                n_cmp++;
                if (bus1.ls_rdata_o !== '0) begin
                    n_bad++; $display("FAIL dut1_ls_rdata_idle: got %h, required 0", bus1.ls_rdata_o);
                end
            end
            if (bus1.if_rvalid_o || bus1.ls_rvalid_o) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut1_rvalid: got if=%b ls=%b at cycle %0d, required none",
                             bus1.if_rvalid_o, bus1.ls_rvalid_o, cyc);
                end else begin
                    e1 = q1.pop_front();
                    if ({bus1.if_rvalid_o, bus1.ls_rvalid_o, bus1.ls_err_o,
                         (e1.is_ls ? bus1.ls_rdata_o : bus1.if_rdata_o)} !==
                        {~e1.is_ls, e1.is_ls, e1.err, e1.rdata} || cyc != e1.due) begin
                        n_bad++;
                        $display("FAIL dut1_resp: got if=%b ls=%b err=%b rd=%h cyc=%0d, required ls=%b err=%b rd=%h cyc=%0d",
                                 bus1.if_rvalid_o, bus1.ls_rvalid_o, bus1.ls_err_o,
                                 (e1.is_ls ? bus1.ls_rdata_o : bus1.if_rdata_o), cyc,
                                 e1.is_ls, e1.err, e1.rdata, e1.due);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus3.if_rvalid_o) begin
                n_cmp++;
                if (bus3.if_rdata_o !== '0) begin
                    n_bad++; $display("FAIL dut3_if_rdata_idle: got %h, required 0", bus3.if_rdata_o);
                end
            end
            if (!bus3.ls_rvalid_o) begin
                n_cmp++;
                if (bus3.ls_rdata_o !== '0) begin
                    n_bad++; $display("FAIL dut3_ls_rdata_idle: got %h, required 0", bus3.ls_rdata_o);
                end
            end
            if (bus3.if_rvalid_o || bus3.ls_rvalid_o) begin
                n_cmp++;
                if (q3.size() == 0) begin
                    n_bad++;
                    $display("FAIL dut3_rvalid: got if=%b ls=%b at cycle %0d, required none",
                             bus3.if_rvalid_o, bus3.ls_rvalid_o, cyc);
                end else begin
                    e3 = q3.pop_front();
                    if ({bus3.if_rvalid_o, bus3.ls_rvalid_o, bus3.ls_err_o,
                         (e3.is_ls ? bus3.ls_rdata_o : bus3.if_rdata_o)} !==
                        {~e3.is_ls, e3.is_ls, e3.err, e3.rdata} || cyc != e3.due) begin
                        n_bad++;
                        $display("FAIL dut3_resp: got if=%b ls=%b err=%b rd=%h cyc=%0d, required ls=%b err=%b rd=%h cyc=%0d",
                                 bus3.if_rvalid_o, bus3.ls_rvalid_o, bus3.ls_err_o,
                                 (e3.is_ls ? bus3.ls_rdata_o : bus3.if_rdata_o), cyc,
                                 e3.is_ls, e3.err, e3.rdata, e3.due);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.if_req_i = 0; bus1.if_addr_i = '0; bus1.ls_req_i = 0; bus1.ls_addr_i = '0;
        bus1.ls_w_rn_i = 0; bus1.ls_width_i = 2'b00; bus1.ls_wdata_i = '0;
        bus3.if_req_i = 0; bus3.if_addr_i = '0; bus3.ls_req_i = 0; bus3.ls_addr_i = '0;
        bus3.ls_w_rn_i = 0; bus3.ls_width_i = 2'b00; bus3.ls_wdata_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs1 !== '0 || outs3 !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got dut1=%h dut3=%h, required 0", outs1, outs3);
        end
        mon_en = 1'b1;
    endtask

    // Both ports held for four grants at latency 1: LSU wins the first tie, then alternate.
    task automatic test_round_robin();
        logic exp_ls;
        tick();
        bus1.if_req_i = 1; bus1.if_addr_i = 16'h0004;
        bus1.ls_req_i = 1; bus1.ls_addr_i = 16'h0008; bus1.ls_width_i = 2'b10; bus1.ls_w_rn_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            exp_ls = (i % 2 == 0);
            n_cmp++;
            if ({bus1.ls_gnt_o, bus1.if_gnt_o, bus1.ram_en_o} !== {exp_ls, ~exp_ls, 1'b1}) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got ls=%b if=%b en=%b, required ls=%b if=%b en=1",
                         i, bus1.ls_gnt_o, bus1.if_gnt_o, bus1.ram_en_o, exp_ls, ~exp_ls);
            end
            q1.push_back('{exp_ls, 1'b0, (exp_ls ? mem[2] : mem[1]), cyc + 1});
            tick();
        end
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_single_fetch();
        tick();
        bus1.if_req_i = 1; bus1.if_addr_i = 16'h0013;
        @(negedge clk);
        n_cmp++;
        if ({bus1.if_gnt_o, bus1.ls_gnt_o, bus1.ram_en_o, bus1.ram_addr_o, bus1.ram_width_o, bus1.ram_w_rn_o}
            !== {1'b1, 1'b0, 1'b1, 16'h0010, 2'b10, 1'b0}) begin
            n_bad++;
            $display("FAIL fetch_grant: got gnt=%b en=%b addr=%h width=%b wrn=%b, required gnt=1 en=1 addr=0010 width=10 wrn=0",
                     bus1.if_gnt_o, bus1.ram_en_o, bus1.ram_addr_o, bus1.ram_width_o, bus1.ram_w_rn_o);
        end
        q1.push_back('{1'b0, 1'b0, 32'hDEADBEEF, cyc + 1});
        tick();
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_load_store();
        tick();
        bus3.ls_req_i = 1; bus3.ls_addr_i = 16'h000C; bus3.ls_width_i = 2'b10; bus3.ls_w_rn_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_w_rn_o} !== {1'b1, 1'b1, 16'h000C, 1'b0}) begin
            n_bad++;
            $display("FAIL load_grant: got gnt=%b en=%b addr=%h wrn=%b, required 1 1 000c 0",
                     bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_w_rn_o);
        end
        q3.push_back('{1'b1, 1'b0, mem[3], cyc + 3});
        tick();
        bus3.ls_addr_i = 16'h0001; bus3.ls_width_i = 2'b00; bus3.ls_w_rn_i = 1; bus3.ls_wdata_i = 32'h000000AA;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_wdata_o} !== '0) begin
                n_bad++;
                $display("FAIL busy_hold%0d: got gnt=%b en=%b addr=%h wdata=%h, required all 0",
                         k, bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_wdata_o);
            end
            tick();
        end
        @(negedge clk);
        n_cmp++;
        if ({bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_w_rn_o, bus3.ram_width_o, bus3.ram_wdata_o}
            !== {1'b1, 1'b1, 16'h0001, 1'b1, 2'b00, 32'h000000AA}) begin
            n_bad++;
            $display("FAIL store_grant: got gnt=%b en=%b addr=%h wrn=%b width=%b wdata=%h, required 1 1 0001 1 00 000000aa",
                     bus3.ls_gnt_o, bus3.ram_en_o, bus3.ram_addr_o, bus3.ram_w_rn_o, bus3.ram_width_o, bus3.ram_wdata_o);
        end
        q3.push_back('{1'b1, 1'b0, 32'h0, cyc + 3});
        tick();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_misaligned();
        tick();
        bus1.ls_req_i = 1; bus1.ls_addr_i = 16'h0005; bus1.ls_width_i = 2'b01; bus1.ls_w_rn_i = 0;
        bus1.if_req_i = 1; bus1.if_addr_i = 16'h0020;
        @(negedge clk);
        n_cmp++;
        if ({bus1.ls_gnt_o, bus1.if_gnt_o, bus1.ram_en_o, bus1.ram_addr_o} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            n_bad++;
            $display("FAIL misalign_grant: got ls=%b if=%b en=%b addr=%h, required 1 0 0 0000",
                     bus1.ls_gnt_o, bus1.if_gnt_o, bus1.ram_en_o, bus1.ram_addr_o);
        end
        q1.push_back('{1'b1, 1'b1, 32'h0, cyc + 1});
        tick();
        bus1.ls_req_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus1.if_gnt_o, bus1.ram_en_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_no_grant: got if_gnt=%b en=%b, required 0 0", bus1.if_gnt_o, bus1.ram_en_o);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus1.if_gnt_o, bus1.ram_en_o, bus1.ram_addr_o} !== {1'b1, 1'b1, 16'h0020}) begin
            n_bad++;
            $display("FAIL fetch_after_err: got gnt=%b en=%b addr=%h, required 1 1 0020",
                     bus1.if_gnt_o, bus1.ram_en_o, bus1.ram_addr_o);
        end
        q1.push_back('{1'b0, 1'b0, mem[8], cyc + 1});
        tick();
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_width11();
        tick();
        bus1.ls_req_i = 1; bus1.ls_addr_i = 16'h0000; bus1.ls_width_i = 2'b11; bus1.ls_w_rn_i = 1;
        @(negedge clk);
        n_cmp++;
        if ({bus1.ls_gnt_o, bus1.ram_en_o, bus1.ram_w_rn_o} !== 3'b100) begin
            n_bad++;
            $display("FAIL width11_grant: got gnt=%b en=%b wrn=%b, required 1 0 0",
                     bus1.ls_gnt_o, bus1.ram_en_o, bus1.ram_w_rn_o);
        end
        q1.push_back('{1'b1, 1'b1, 32'h0, cyc + 1});
        tick();
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        tick();
        bus3.if_req_i = 1; bus3.if_addr_i = 16'h0010;
        @(negedge clk);
        n_cmp++;
        if (bus3.if_gnt_o !== 1'b1) begin
            n_bad++; $display("FAIL midrst_grant: got %b, required 1", bus3.if_gnt_o);
        end
        tick();
        bus3.if_req_i = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 2; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (outs3 !== '0) begin
                n_bad++; $display("FAIL midrst_outputs_t%0d: got %h, required 0", k, outs3);
            end
            tick();
        end
        bus3.if_req_i = 1; bus3.if_addr_i = 16'h0004;
        bus3.ls_req_i = 1; bus3.ls_addr_i = 16'h0008; bus3.ls_width_i = 2'b10; bus3.ls_w_rn_i = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus3.ls_gnt_o, bus3.if_gnt_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_tie: got ls=%b if=%b, required ls=1 if=0", bus3.ls_gnt_o, bus3.if_gnt_o);
        end
        q3.push_back('{1'b1, 1'b0, mem[2], cyc + 3});
        tick();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_drain();
        int budget;
        budget = 0;
        while ((q1.size() != 0 || q3.size() != 0) && budget < 20) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d responses still missing, required 0/0", q1.size(), q3.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        mem[4] = 32'hDEADBEEF;
        idle_inputs();
        test_reset();
        test_round_robin();
        test_single_fetch();
        test_load_store();
        test_misaligned();
        test_width11();
        test_reset_mid();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
